// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and byte-level helpers (S-box, xtime).
package aes_pkg;
  localparam int WORD = 32;
  localparam int NB   = 4;
  localparam int NK   = 4;
  localparam int NR   = 10;

  typedef enum logic {IDLE, EXPAND} state_e;

  // Byte 0x00 is the leftmost entry of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/key_subword.sv
// Four parallel S-box lookups on a 32-bit word; shared with the SubBytes stage.
module key_subword
  import aes_pkg::*;
(
  input  logic [WORD-1:0] word_i,
  output logic [WORD-1:0] word_o
);
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
  end
endmodule

// File: rtl/key_expansion.sv
// On-the-fly AES-128 key schedule: one round key per cycle, rounds 0..NR.
// Define KEY_ZEROIZE_EN to clear key material on the cycle after the last round.
module key_expansion
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD*NK-1:0]   i_key,
  output logic                 o_valid,
  output logic [WORD*NB-1:0]   o_roundkey,
  output logic [3:0]           o_round,
  output logic                 o_last
);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_e             state_q, state_d;
  logic [WORD*NB-1:0] key_q, key_d;
  logic [3:0]         round_q, round_d;
  logic [7:0]         rcon_q, rcon_d;

  logic [WORD-1:0]    w0, w1, w2, w3, rot_w3, sub_w3, temp;
  logic [WORD-1:0]    n0, n1, n2, n3;
  logic               at_last;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  key_subword u_subword (
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  assign temp    = sub_w3 ^ {rcon_q, 24'h0};
  assign n0      = w0 ^ temp;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign at_last = (round_q == LAST_ROUND);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = EXPAND;
      EXPAND:  if (at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == EXPAND);
    o_last  = (state_q == EXPAND) && at_last;
  end

  always_comb begin
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          key_d   = i_key;
          round_d = '0;
          rcon_d  = 8'h01;
        end
      end
      EXPAND: begin
        if (at_last) begin
`ifdef KEY_ZEROIZE_EN
          key_d   = '0;
          round_d = '0;
`endif
        end else begin
          key_d   = {n0, n1, n2, n3};
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  assign o_roundkey = key_q;
  assign o_round    = round_q;
endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion; reference schedule built from GF(2^8) arithmetic.
module tb_key_expansion;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_valid = 1'b0;
  logic [127:0] i_key = '0;
  logic         o_ready, o_valid, o_last;
  logic [127:0] o_roundkey;
  logic [3:0]   o_round;

  key_expansion dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_key      (i_key),
    .o_valid    (o_valid),
    .o_roundkey (o_roundkey),
    .o_round    (o_round),
    .o_last     (o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[256];
  logic       ready_s = 1'b1;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ONES_KEY = {128{1'b1}};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from multiplicative inverse followed by the affine transform.
  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gf_mul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expected(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      exp_q.push_back('{rk: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, rnd: 4'(r), last: (r == 10)});
  endtask

  // Acceptance detector: ready_s is the ready level seen in the preceding low phase.
  always @(posedge clk)
    if (rst && i_valid && ready_s) push_expected(i_key);

  always @(negedge clk) begin
    ready_s <= o_ready;
    if (rst) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: o_valid=1 round %0d, expected no output", o_round);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_roundkey", o_roundkey, mon_e.rk);
          check("sb_round", 128'(o_round), 128'(mon_e.rnd));
          check("sb_last", 128'(o_last), 128'(mon_e.last));
        end
      end else begin
        check("sb_last_idle", 128'(o_last), 128'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: o_ready got 0 expected 1 within 50 cycles");
    end
  endtask

  // Returns at the low phase of the first output cycle (round 0).
  task automatic accept(input logic [127:0] key);
    @(negedge clk);
    wait_ready();
    i_valid = 1'b1;
    i_key   = key;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    build_sbox();

    #1;
    check("rst_ready", 128'(o_ready), 128'd1);
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_last", 128'(o_last), 128'd0);
    check("rst_round", 128'(o_round), 128'd0);
    check("rst_roundkey", o_roundkey, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // FIPS-197 vector with exact cycle positions
    accept(FIPS_KEY);
    check("fips_r0_valid", 128'(o_valid), 128'd1);
    check("fips_r0_round", 128'(o_round), 128'd0);
    check("fips_r0_key", o_roundkey, FIPS_KEY);
    @(negedge clk);
    check("fips_r1_key", o_roundkey, 128'ha0fafe1788542cb123a339392a6c7605);
    repeat (9) @(negedge clk);
    check("fips_r10_key", o_roundkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_r10_last", 128'(o_last), 128'd1);
    check("fips_r10_round", 128'(o_round), 128'd10);
    @(negedge clk);
    check("fips_after_valid", 128'(o_valid), 128'd0);
    check("fips_after_ready", 128'(o_ready), 128'd1);
`ifdef KEY_ZEROIZE_EN
    check("zeroize_key", o_roundkey, 128'd0);
    check("zeroize_round", 128'(o_round), 128'd0);
`else
    check("hold_key", o_roundkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("hold_round", 128'(o_round), 128'd10);
`endif

    // All-zero key exercises the rcon wrap 80 -> 1b -> 36
    accept(128'd0);
    @(negedge clk);
    check("zero_r1_key", o_roundkey, 128'h62636363626363636263636362636363);
    repeat (9) @(negedge clk);
    check("zero_r10_key", o_roundkey, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    @(negedge clk);

    // Second key presented during expansion is held off until after o_last
    accept(FIPS_KEY);
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b1;
    i_key   = ONES_KEY;
    repeat (8) @(negedge clk);
    check("b2b_first_last", 128'(o_last), 128'd1);
    check("b2b_first_r10", o_roundkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    check("b2b_gap_valid", 128'(o_valid), 128'd0);
    check("b2b_gap_ready", 128'(o_ready), 128'd1);
    @(negedge clk);
    i_valid = 1'b0;
    check("b2b_second_r0", o_roundkey, ONES_KEY);
    check("b2b_second_round", 128'(o_round), 128'd0);
    @(negedge clk);
    check("b2b_second_r1", o_roundkey, 128'he8e9e9e917161616e8e9e9e917161616);
    repeat (10) @(negedge clk);

    // Reset in the middle of an expansion
    accept(rand_key());
    repeat (5) @(negedge clk);
    check("abort_round_pre", 128'(o_round), 128'd5);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_valid", 128'(o_valid), 128'd0);
    check("abort_last", 128'(o_last), 128'd0);
    check("abort_round", 128'(o_round), 128'd0);
    check("abort_key", o_roundkey, 128'd0);
    check("abort_ready", 128'(o_ready), 128'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", 128'(o_valid), 128'd0);
      check("post_rst_ready", 128'(o_ready), 128'd1);
    end

    // i_valid held high: two bursts separated by one idle cycle
    i_valid = 1'b1;
    i_key   = rand_key();
    n = 0;
    while (!o_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k <= 10; k++) begin
      check("hold_b1_valid", 128'(o_valid), 128'd1);
      check("hold_b1_round", 128'(o_round), 128'(k));
      @(negedge clk);
    end
    check("hold_gap_valid", 128'(o_valid), 128'd0);
    @(negedge clk);
    for (int k = 0; k <= 10; k++) begin
      check("hold_b2_valid", 128'(o_valid), 128'd1);
      check("hold_b2_round", 128'(o_round), 128'(k));
      if (k < 10) @(negedge clk);
    end
    i_valid = 1'b0;

    // Random keys with random idle gaps
    for (int j = 0; j < 8; j++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept(rand_key());
    end

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 128'(exp_q.size()), 128'd0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
